// File: rtl/alt_vipitc121_is2vid_genlock_apply_pkg.sv
// Shared encodings and widths for the IS2Vid genlock apply block.
// The clamp helpers bound a requested offset to the current frame totals.
package alt_vipitc121_is2vid_genlock_apply_pkg;

  localparam int H_W = 14;
  localparam int V_W = 13;

  typedef enum logic {
    GA_RUN   = 1'b0,
    GA_STALL = 1'b1
  } ga_state_e;

  function automatic logic [H_W-1:0] clamp_h(input logic [H_W-1:0] req,
                                             input logic [H_W-1:0] total);
    return (req > total) ? total : req;
  endfunction

  function automatic logic [V_W-1:0] clamp_v(input logic [V_W-1:0] req,
                                             input logic [V_W-1:0] total);
    return (req > total) ? total : req;
  endfunction

endpackage

// File: rtl/alt_vipitc121_is2vid_genlock_stall_counter.sv
// Two-dimensional (line, sample) down-counter that times a repeat stall.
// Linear value is stall_v*(h_total+1)+stall_h; clear beats load beats dec.
module alt_vipitc121_is2vid_genlock_stall_counter
  import alt_vipitc121_is2vid_genlock_apply_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           load,
  input  logic           dec,
  input  logic [H_W-1:0] h_total,
  input  logic [H_W-1:0] load_h,
  input  logic [V_W-1:0] load_v,
  output logic [H_W-1:0] stall_h,
  output logic [V_W-1:0] stall_v,
  output logic           zero,
  output logic           last
);

  assign zero = (stall_h == '0) && (stall_v == '0);
  assign last = (stall_h == H_W'(1)) && (stall_v == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_h <= '0;
      stall_v <= '0;
    end else if (clear) begin
      stall_h <= '0;
      stall_v <= '0;
    end else if (load) begin
      stall_h <= load_h;
      stall_v <= load_v;
    end else if (dec && !zero) begin
      if (stall_h != '0) begin
        stall_h <= stall_h - H_W'(1);
      end else begin
        // Borrow a whole line: the sample field restarts at the current line length.
        stall_h <= h_total;
        stall_v <= stall_v - V_W'(1);
      end
    end
  end

endmodule

// File: rtl/alt_vipitc121_is2vid_genlock_apply.sv
// CVO output timing counter that applies comparator corrections, one per frame:
// remove jumps the position forward, repeat stalls at the frame end.
module alt_vipitc121_is2vid_genlock_apply
  import alt_vipitc121_is2vid_genlock_apply_pkg::*;
#(
  parameter int GUARD_FRAMES = 2,
  parameter int LOCK_FRAMES  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           count_enable,
  input  logic           restart,
  input  logic [1:0]     genlock_enable,
  input  logic [H_W-1:0] h_total_minus_one,
  input  logic [V_W-1:0] v_total_minus_one,
  input  logic           sync_lines,
  input  logic           sync_samples,
  input  logic           remove_repeatn,
  input  logic [12:0]    sync_compare_h_reset,
  input  logic [V_W-1:0] sync_compare_v_reset,
  input  logic           genlocked,
  output logic [H_W-1:0] h_count,
  output logic [V_W-1:0] v_count,
  output logic           sof,
  output logic           sof_locked,
  output logic           correcting,
  output logic           correction_applied
);

  localparam int GW = $clog2(GUARD_FRAMES + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);

  ga_state_e      state;
  logic [GW-1:0]  guard_cnt;
  logic [LW-1:0]  lock_cnt;
  logic [LW-1:0]  lock_nxt;
  logic [H_W-1:0] h_off;
  logic [V_W-1:0] v_off;
  logic [H_W-1:0] h_adv;
  logic [V_W-1:0] v_adv;
  logic           ge_on;
  logic           frame_end;
  logic           commit;
  logic           stall_load;
  logic           stall_dec;
  logic           stall_exit;
  logic [H_W-1:0] stall_h;
  logic [V_W-1:0] stall_v;
  logic           stall_zero;
  logic           stall_last;

  always_comb begin
    h_off     = clamp_h({1'b0, sync_compare_h_reset}, h_total_minus_one);
    v_off     = clamp_v(sync_compare_v_reset, v_total_minus_one);
    ge_on     = (genlock_enable == 2'b11);
    frame_end = (state == GA_RUN) && count_enable &&
                (h_count == h_total_minus_one) && (v_count == v_total_minus_one);
    commit    = frame_end && (guard_cnt == '0) && ge_on &&
                (sync_lines || sync_samples) &&
                ({sync_compare_v_reset, sync_compare_h_reset} != '0);
    stall_load = commit && !remove_repeatn && !restart;
    stall_dec  = (state == GA_STALL) && count_enable;
    stall_exit = stall_dec && (stall_last || stall_zero);

    // Out-of-range positions (totals shrunk mid-frame) wrap on the next enable.
    if (h_count >= h_total_minus_one) begin
      h_adv = '0;
      v_adv = (v_count >= v_total_minus_one) ? '0 : v_count + V_W'(1);
    end else begin
      h_adv = h_count + H_W'(1);
      v_adv = v_count;
    end

    lock_nxt = lock_cnt;
    if (restart || !ge_on || commit) begin
      lock_nxt = '0;
    end else if (frame_end) begin
      if (!genlocked) begin
        lock_nxt = '0;
      end else if ((guard_cnt == '0) && (lock_cnt != LW'(LOCK_FRAMES))) begin
        lock_nxt = lock_cnt + LW'(1);
      end
    end
  end

  alt_vipitc121_is2vid_genlock_stall_counter u_stall (
    .clk     (clk),
    .rst     (rst),
    .clear   (restart),
    .load    (stall_load),
    .dec     (stall_dec),
    .h_total (h_total_minus_one),
    .load_h  (h_off),
    .load_v  (v_off),
    .stall_h (stall_h),
    .stall_v (stall_v),
    .zero    (stall_zero),
    .last    (stall_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= GA_RUN;
      h_count            <= '0;
      v_count            <= '0;
      guard_cnt          <= '0;
      lock_cnt           <= '0;
      sof                <= 1'b1;
      sof_locked         <= 1'b0;
      correcting         <= 1'b0;
      correction_applied <= 1'b0;
    end else begin
      correction_applied <= 1'b0;
      lock_cnt           <= lock_nxt;
      sof_locked         <= (lock_nxt == LW'(LOCK_FRAMES));
      if (restart) begin
        state      <= GA_RUN;
        h_count    <= '0;
        v_count    <= '0;
        guard_cnt  <= '0;
        sof        <= 1'b1;
        correcting <= 1'b0;
      end else begin
        case (state)
          GA_RUN: begin
            if (commit) begin
              correction_applied <= 1'b1;
              if (remove_repeatn) begin
                h_count   <= h_off;
                v_count   <= v_off;
                guard_cnt <= GW'(GUARD_FRAMES);
                sof       <= (h_off == '0) && (v_off == '0);
              end else begin
                // Position stays parked on the last sample while the stall runs.
                state      <= GA_STALL;
                correcting <= 1'b1;
                sof        <= 1'b0;
              end
            end else if (count_enable) begin
              h_count <= h_adv;
              v_count <= v_adv;
              sof     <= (h_adv == '0) && (v_adv == '0);
              if (frame_end && (guard_cnt != '0)) begin
                guard_cnt <= guard_cnt - GW'(1);
              end
            end
          end
          GA_STALL: begin
            if (stall_exit) begin
              state      <= GA_RUN;
              h_count    <= '0;
              v_count    <= '0;
              guard_cnt  <= GW'(GUARD_FRAMES);
              sof        <= 1'b1;
              correcting <= 1'b0;
            end
          end
          default: begin
            state <= GA_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alt_vipitc121_is2vid_genlock_apply.sv
// Directed bench for the genlock apply block: 10x5 frame, remove/repeat
// corrections, guard window, clamping, restart, reset and gated enables.
module tb_alt_vipitc121_is2vid_genlock_apply;

  logic        clk;
  logic        rst;
  logic        count_enable;
  logic        restart;
  logic [1:0]  genlock_enable;
  logic [13:0] h_total_minus_one;
  logic [12:0] v_total_minus_one;
  logic        sync_lines;
  logic        sync_samples;
  logic        remove_repeatn;
  logic [12:0] sync_compare_h_reset;
  logic [12:0] sync_compare_v_reset;
  logic        genlocked;
  logic [13:0] h_count;
  logic [12:0] v_count;
  logic        sof;
  logic        sof_locked;
  logic        correcting;
  logic        correction_applied;

  int          n_checks;
  int          n_pass;
  logic        gate_mode;
  logic [15:0] exp_q[$];

  alt_vipitc121_is2vid_genlock_apply dut (
    .clk                  (clk),
    .rst                  (rst),
    .count_enable         (count_enable),
    .restart              (restart),
    .genlock_enable       (genlock_enable),
    .h_total_minus_one    (h_total_minus_one),
    .v_total_minus_one    (v_total_minus_one),
    .sync_lines           (sync_lines),
    .sync_samples         (sync_samples),
    .remove_repeatn       (remove_repeatn),
    .sync_compare_h_reset (sync_compare_h_reset),
    .sync_compare_v_reset (sync_compare_v_reset),
    .genlocked            (genlocked),
    .h_count              (h_count),
    .v_count              (v_count),
    .sof                  (sof),
    .sof_locked           (sof_locked),
    .correcting           (correcting),
    .correction_applied   (correction_applied)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gate_mode) count_enable = ~count_enable;
  endtask

  task automatic wait_sof(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sof && n < 300);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(h_count) == h && int'(v_count) == v) && n < 300) begin
      tick();
      n++;
    end
    check_eq("run_to_pos", int'(h_count) * 100 + int'(v_count), h * 100 + v);
  endtask

  task automatic check_pos(input string tag, input int h, input int v);
    check_eq(tag, int'(h_count) * 100 + int'(v_count), h * 100 + v);
  endtask

  task automatic request(input logic rr, input int h, input int v);
    remove_repeatn       = rr;
    sync_samples         = rr;
    sync_lines           = ~rr;
    sync_compare_h_reset = 13'(h);
    sync_compare_v_reset = 13'(v);
  endtask

  task automatic clear_request();
    sync_samples         = 1'b0;
    sync_lines           = 1'b0;
    sync_compare_h_reset = '0;
    sync_compare_v_reset = '0;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass = 0;
    gate_mode = 1'b0;
    rst = 1'b0;
    count_enable = 1'b1;
    restart = 1'b0;
    genlock_enable = 2'b11;
    h_total_minus_one = 14'd9;
    v_total_minus_one = 13'd4;
    genlocked = 1'b1;
    remove_repeatn = 1'b0;
    clear_request();

    // reset state
    tick();
    rst = 1'b1;
    check_pos("reset_pos", 0, 0);
    check_eq("reset_sof", int'(sof), 1);
    check_eq("reset_locked", int'(sof_locked), 0);
    check_eq("reset_correcting", int'(correcting), 0);
    check_eq("reset_applied", int'(correction_applied), 0);

    // free-running frames: sof every 50 enables, lock after 4 clean frames
    for (int i = 0; i < 4; i++) exp_q.push_back(16'd50);
    for (int i = 0; i < 4; i++) begin
      wait_sof(n);
      check_eq("sof_gap", n, int'(exp_q.pop_front()));
      check_eq("sof_locked_progress", int'(sof_locked), (i == 3) ? 1 : 0);
    end
    tick();
    check_eq("sof_one_cycle", int'(sof), 0);

    // remove (3,2): jump, pulse, lock lost, 27 enables to next sof
    request(1'b1, 3, 2);
    run_to(9, 4);
    tick();
    check_pos("remove_pos", 3, 2);
    check_eq("remove_applied", int'(correction_applied), 1);
    check_eq("remove_unlock", int'(sof_locked), 0);
    clear_request();
    tick();
    check_eq("remove_pulse_end", int'(correction_applied), 0);
    wait_sof(n);
    check_eq("remove_sof_gap", n + 1, 27);

    // guard still open: request ignored
    request(1'b1, 1, 1);
    run_to(9, 4);
    tick();
    check_pos("guard_ignore_pos", 0, 0);
    check_eq("guard_ignore_applied", int'(correction_applied), 0);
    clear_request();

    // repeat (4,1): 14 enables of stall parked at (9,4)
    request(1'b0, 4, 1);
    run_to(9, 4);
    tick();
    check_eq("repeat_applied", int'(correction_applied), 1);
    check_eq("repeat_correcting", int'(correcting), 1);
    check_eq("repeat_sof", int'(sof), 0);
    clear_request();
    tick();
    check_pos("stall_frozen", 9, 4);
    n = 0;
    while (correcting && n < 100) begin
      n++;
      tick();
    end
    check_eq("stall_length", n + 1, 14);
    check_pos("stall_exit_pos", 0, 0);
    check_eq("stall_exit_sof", int'(sof), 1);

    // two guarded frames ignore a standing remove, the third commits
    request(1'b1, 3, 2);
    wait_sof(n);
    check_eq("guard_frame1", n, 50);
    wait_sof(n);
    check_eq("guard_frame2", n, 50);
    run_to(9, 4);
    tick();
    check_pos("guard_done_pos", 3, 2);
    check_eq("guard_done_applied", int'(correction_applied), 1);
    clear_request();

    // clamping: h_reset=20 jumps to h=9
    wait_sof(n);
    wait_sof(n);
    request(1'b1, 20, 0);
    run_to(9, 4);
    tick();
    check_pos("clamp_pos", 9, 0);
    check_eq("clamp_applied", int'(correction_applied), 1);
    clear_request();

    // genlock_enable=01: request ignored
    wait_sof(n);
    check_eq("clamp_sof_gap", n, 41);
    wait_sof(n);
    genlock_enable = 2'b01;
    request(1'b1, 3, 2);
    run_to(9, 4);
    tick();
    check_pos("ge01_pos", 0, 0);
    check_eq("ge01_applied", int'(correction_applied), 0);
    genlock_enable = 2'b11;
    clear_request();

    // restart mid-stall
    request(1'b0, 4, 1);
    run_to(9, 4);
    tick();
    check_eq("restart_stall_entered", int'(correcting), 1);
    clear_request();
    tick();
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_pos("restart_stall_pos", 0, 0);
    check_eq("restart_stall_correcting", int'(correcting), 0);
    check_eq("restart_stall_applied", int'(correction_applied), 0);
    check_eq("restart_stall_sof", int'(sof), 1);
    tick();
    check_pos("restart_stall_runs", 1, 0);

    // restart coincident with a committing frame end
    request(1'b1, 3, 2);
    run_to(9, 4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    clear_request();
    check_pos("restart_fe_pos", 0, 0);
    check_eq("restart_fe_applied", int'(correction_applied), 0);
    tick();
    check_pos("restart_fe_runs", 1, 0);

    // relock, then reset mid-frame at (5,3)
    for (int i = 0; i < 4; i++) wait_sof(n);
    check_eq("relock", int'(sof_locked), 1);
    run_to(5, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_pos("rst_mid_pos", 0, 0);
    check_eq("rst_mid_sof", int'(sof), 1);
    check_eq("rst_mid_locked", int'(sof_locked), 0);
    check_eq("rst_mid_applied", int'(correction_applied), 0);
    check_eq("rst_mid_correcting", int'(correcting), 0);

    // 50% enable: stall of 14 enables takes 28 cycles
    gate_mode = 1'b1;
    request(1'b0, 4, 1);
    n = 0;
    while (!correcting && n < 400) begin
      tick();
      n++;
    end
    check_eq("gated_applied", int'(correction_applied), 1);
    clear_request();
    n = 0;
    while (correcting && n < 200) begin
      n++;
      tick();
    end
    check_eq("gated_stall_length", n, 28);
    check_pos("gated_exit_pos", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
